// File: rtl/obi_wb_bridge.sv
// OBI request/grant/rvalid to Wishbone classic master bridge with a registered
// request stage, a response FIFO with rready back-pressure, and an optional bus timeout.
module obi_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RSP_DEPTH      = 2,
  parameter int WRITE_RSP      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
  localparam int TMO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_e;

  state_e                  state_q;
  logic                    cyc_q;
  logic                    we_q;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [TMO_W-1:0]        tmo_q;

  logic [DATA_WIDTH:0]     mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        count_q;

  logic                    hs_s;
  logic                    tmo_hit_s;
  logic                    term_s;
  logic                    rsp_err_s;
  logic [DATA_WIDTH-1:0]   rsp_data_s;
  logic                    push_s;
  logic                    pop_s;
  logic [DATA_WIDTH:0]     head_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(RSP_DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Grant only from IDLE with a free slot; a same-cycle pop does not count.
  assign gnt_o     = (state_q == IDLE) && (count_q < CNT_FULL);
  assign hs_s      = req_i & gnt_o;
  assign tmo_hit_s = (TIMEOUT_CYCLES > 0) && (tmo_q == TMO_LAST);
  assign term_s    = (state_q == BUS) && (wb_ack_i || wb_err_i || tmo_hit_s);
  // No ack and no err at termination means the timeout fired.
  assign rsp_err_s  = wb_err_i | ~wb_ack_i;
  assign rsp_data_s = (!we_q && wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
  assign push_s     = term_s && (!we_q || (WRITE_RSP != 0));
  assign pop_s      = rvalid_o & rready_i;

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

  assign head_s   = mem_q[rd_ptr_q];
  assign rvalid_o = (count_q != '0);
  assign rdata_o  = rvalid_o ? head_s[DATA_WIDTH:1] : '0;
  assign err_o    = rvalid_o & head_s[0];

  // Request-stage FSM: latch the OBI request and hold the Wishbone cycle until it terminates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_s) begin
            state_q <= BUS;
            cyc_q   <= 1'b1;
            we_q    <= we_i;
            sel_q   <= be_i;
            adr_q   <= addr_i;
            dat_q   <= wdata_i;
            tmo_q   <= '0;
          end
        end
        BUS: begin
          if (term_s) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
          end else if (TIMEOUT_CYCLES > 0) begin
            tmo_q <= tmo_q + TMO_W'(1);
          end else begin
            tmo_q <= tmo_q;
          end
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  // Response FIFO: {rdata, err} entries, pushed on termination, popped on rvalid & rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {rsp_data_s, rsp_err_s};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Scoreboard bench for obi_wb_bridge: a scripted Wishbone slave, expected responses
// queued at grant time and compared when the bridge presents them.
module tb_obi_wb_bridge;

  localparam int WRITE_RSP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] rdata;
  logic        err;
  logic        cyc, stb, wwe;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] wdin = 32'h0;
  logic        ack = 1'b0;
  logic        werr = 1'b0;

  logic        req2 = 1'b0;
  logic        gnt2, rvalid2, err2, cyc2, stb2, we2o;
  logic [31:0] rdata2, adr2, dat2o;
  logic [3:0]  sel2;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  int          cyc_run = 0;
  int          last_run = 0;
  int          beats2 = 0;

  int          slv_wait = 0;
  int          slv_cnt = 0;
  logic        slv_hang = 1'b0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_data = 32'h0;

  always #5 clk = ~clk;

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RSP_DEPTH(2), .WRITE_RSP(WRITE_RSP),
                  .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
    .err_o(err), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(wwe), .wb_sel_o(sel),
    .wb_adr_o(adr), .wb_dat_o(wdat), .wb_dat_i(wdin), .wb_ack_i(ack), .wb_err_i(werr));

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RSP_DEPTH(2), .WRITE_RSP(0),
                  .TIMEOUT_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req2), .gnt_o(gnt2), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid2), .rready_i(1'b1), .rdata_o(rdata2),
    .err_o(err2), .wb_cyc_o(cyc2), .wb_stb_o(stb2), .wb_we_o(we2o), .wb_sel_o(sel2),
    .wb_adr_o(adr2), .wb_dat_o(dat2o), .wb_dat_i(32'hA5A5_A5A5), .wb_ack_i(cyc2),
    .wb_err_i(1'b0));

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Slave: acks slv_wait cycles into the bus cycle unless hung; drives away from the edge.
  always begin
    @(posedge clk);
    #2;
    if (cyc && !slv_hang && slv_cnt == slv_wait) begin
      ack  = 1'b1;
      werr = slv_err;
      wdin = slv_data;
    end else begin
      ack  = 1'b0;
      werr = 1'b0;
      wdin = 32'h0BAD_0BAD;
    end
    if (cyc) slv_cnt++;
    else     slv_cnt = 0;
  end

  // Monitor: cycle-length tracking and scoreboard pop on each accepted response.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      if (cyc) cyc_run++;
      else if (cyc_run > 0) begin
        last_run = cyc_run;
        cyc_run  = 0;
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) check_eq("unexpected_rsp", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check_eq("rdata", {32'h0, rdata}, {32'h0, e[32:1]});
          check_eq("err", {63'h0, err}, {63'h0, e[0]});
        end
      end
      if (rvalid2) begin
        beats2++;
        check_eq("rdata2", {32'h0, rdata2}, 64'hA5A5_A5A5);
      end
    end
  end

  // Issue one OBI request; the slave's reply is set up right after the grant edge.
  task automatic obi_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd, input logic [31:0] rsp, input logic rerr);
    int n = 0;
    req = 1'b1; addr = a; we = w; be = b; wdata = wd;
    while (!gnt && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      check_eq("gnt_wait", 64'd0, 64'd1);
      req = 1'b0;
    end else begin
      @(posedge clk); #1;
      req = 1'b0;
      slv_data = rsp;
      slv_err  = rerr;
      if (!w || WRITE_RSP != 0) exp_q.push_back({(w || rerr) ? 32'h0 : rsp, rerr});
    end
  endtask

  task automatic req2_go();
    int n = 0;
    req2 = 1'b1;
    while (!gnt2 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("gnt2_wait", {63'h0, gnt2}, 64'd1);
    @(posedge clk); #1;
    req2 = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cyc", {63'h0, cyc}, 64'd0);
    check_eq("rst_rvalid", {63'h0, rvalid}, 64'd0);
    check_eq("rst_rdata_err", {31'h0, rdata, err}, 64'd0);
    check_eq("rst_wb_regs", {sel, adr, wwe}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_gnt", {63'h0, gnt}, 64'd1);

    // zero-wait read
    @(posedge clk); #1;
    obi_req(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check_eq("rd_cyc", {62'h0, cyc, stb}, 64'd3);
    check_eq("rd_adr", {32'h0, adr}, 64'h100);
    check_eq("rd_gnt_bus", {63'h0, gnt}, 64'd0);
    check_eq("rd_rvalid_early", {63'h0, rvalid}, 64'd0);
    @(negedge clk);
    check_eq("rd_cyc_done", {63'h0, cyc}, 64'd0);
    check_eq("rd_rvalid", {63'h0, rvalid}, 64'd1);
    @(negedge clk);
    check_eq("rd_cyc_len", last_run, 64'd1);

    // write with one wait state
    slv_wait = 1;
    @(posedge clk); #1;
    obi_req(32'h200, 1'b1, 4'b0011, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    check_eq("wr_we_sel", {59'h0, wwe, sel}, {59'h0, 1'b1, 4'b0011});
    check_eq("wr_dat", {32'h0, wdat}, 64'h1234_5678);
    repeat (4) @(posedge clk);
    #1;
    check_eq("wr_rsp_drained", exp_q.size(), 64'd0);

    // silent write then read on the WRITE_RSP=0 bridge
    addr = 32'h240; we = 1'b1; be = 4'b0011; wdata = 32'h1234_5678;
    req2_go();
    @(negedge clk);
    check_eq("wr2_we_sel", {59'h0, we2o, sel2}, {59'h0, 1'b1, 4'b0011});
    repeat (3) @(posedge clk);
    #1;
    we = 1'b0; be = 4'hF;
    req2_go();
    repeat (4) @(posedge clk);
    #1;
    check_eq("wr2_beats", beats2, 64'd1);

    // back-pressure: depth 2, third read waits for the first pop
    slv_wait = 0;
    rready = 1'b0;
    obi_req(32'h10, 1'b0, 4'hF, 32'h0, 32'hA1, 1'b0);
    obi_req(32'h14, 1'b0, 4'hF, 32'h0, 32'hA2, 1'b0);
    req = 1'b1; addr = 32'h18; we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_gnt_low", {63'h0, gnt}, 64'd0);
    end
    check_eq("bp_rvalid", {63'h0, rvalid}, 64'd1);
    @(posedge clk); #1;
    rready = 1'b1;
    @(negedge clk);
    check_eq("bp_gnt_prepop", {63'h0, gnt}, 64'd0);
    @(negedge clk);
    check_eq("bp_gnt_postpop", {63'h0, gnt}, 64'd1);
    @(posedge clk); #1;
    req = 1'b0;
    slv_data = 32'hA3; slv_err = 1'b0;
    exp_q.push_back({32'hA3, 1'b0});
    repeat (5) @(posedge clk);
    #1;
    check_eq("bp_drained", exp_q.size(), 64'd0);

    // error together with ack
    obi_req(32'h300, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    slv_err = 1'b0;

    // timeout: slave never answers
    slv_hang = 1'b1;
    obi_req(32'h400, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (cyc && n < 30);
    check_eq("tmo_gnt", {63'h0, gnt}, 64'd1);
    @(negedge clk);
    check_eq("tmo_cyc_len", last_run, 64'd8);
    slv_hang = 1'b0;
    slv_err = 1'b0;

    // reset while a response is queued and a cycle is in flight
    @(posedge clk); #1;
    rready = 1'b0;
    obi_req(32'h500, 1'b0, 4'hF, 32'h0, 32'h11, 1'b0);
    slv_wait = 20;
    obi_req(32'h600, 1'b0, 4'hF, 32'h0, 32'h22, 1'b0);
    @(posedge clk); #1;
    check_eq("mid_cyc", {62'h0, cyc, rvalid}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_cyc", {62'h0, cyc, stb}, 64'd0);
    check_eq("async_rst_rvalid", {63'h0, rvalid}, 64'd0);
    exp_q.delete();
    cyc_run = 0;
    slv_wait = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rready = 1'b1;
    obi_req(32'h700, 1'b0, 4'hF, 32'h0, 32'h7777, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("post_rst_drained", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_wb_bridge.md
# obi_wb_bridge

Parametrised bridge between a core-side OBI request/grant/rvalid port and a Wishbone classic master port, used in `processorci_top` wrappers for both the instruction and data buses. It replaces the fixed one-register delay with a registered request stage and a response FIFO (with optional `rready_i` back-pressure). It adds byte-select forwarding, a configurable write-response policy, and a bus timeout that returns an error instead of hanging the core.

## Interface
- `ADDR_WIDTH`, 32, address width on both sides.
- `DATA_WIDTH`, 32, data width; multiple of 8; `SEL_WIDTH = DATA_WIDTH/8`.
- `RSP_DEPTH`, 2, response FIFO entries; power of two, ≥1.
- `WRITE_RSP`, 1, 1: writes produce an `rvalid_o` beat; 0: write completions are silent.
- `TIMEOUT_CYCLES`, 0, bus cycles before forced error completion; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_i` in 1: OBI request.
- `gnt_o` out 1: OBI grant (combinational).
- `addr_i` in ADDR_WIDTH: request address.
- `we_i` in 1: 1 = write.
- `be_i` in SEL_WIDTH: byte enables.
- `wdata_i` in DATA_WIDTH: write data.
- `rvalid_o` out 1: response valid (FIFO not empty).
- `rready_i` in 1: response accept; tie high for plain OBI.
- `rdata_o` out DATA_WIDTH: response data (0 for writes and errors).
- `err_o` out 1: response error flag.
- `wb_cyc_o`, `wb_stb_o` out 1: Wishbone cycle/strobe, always equal.
- `wb_we_o` out 1: Wishbone write enable.
- `wb_sel_o` out SEL_WIDTH: byte selects.
- `wb_adr_o` out ADDR_WIDTH: address.
- `wb_dat_o` out DATA_WIDTH: write data.
- `wb_dat_i` in DATA_WIDTH: read data.
- `wb_ack_i` in 1: termination, normal.
- `wb_err_i` in 1: termination, error.

## Operation
- FSM has two states, IDLE and BUS. Only one Wishbone transaction is in flight.
- In IDLE, `gnt_o = (count < RSP_DEPTH)`. `count` is the registered FIFO occupancy; a pop in the same cycle does not free a slot early.
- When `req_i & gnt_o`: latch `addr/we/be/wdata` into `wb_*` registers, clear the timeout counter, go to BUS.
- In BUS: `wb_cyc_o = wb_stb_o = 1` and `gnt_o = 0`; the `wb_*` outputs stay stable.
- On `wb_ack_i | wb_err_i`: push `{rdata, err}` and return to IDLE. `cyc/stb` deassert on that edge.
  - `err = wb_err_i`; err wins if both are asserted.
  - `rdata = wb_dat_i` for successful reads; 0 otherwise.
  - The push is skipped when `we` is set and `WRITE_RSP=0`.
- Timeout (`TIMEOUT_CYCLES>0`): the counter increments each BUS cycle. When it has counted `TIMEOUT_CYCLES` cycles with no termination, complete with err=1 and rdata=0. The push follows the same `WRITE_RSP` rule. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- FIFO: `rvalid_o = !empty`; `rdata_o`/`err_o` are taken from the head. Pop when `rvalid_o & rready_i`. A simultaneous push and pop leaves `count` unchanged. Pointers wrap modulo `RSP_DEPTH`.
- `wb_ack_i`/`wb_err_i` seen in IDLE are ignored.

## Timing
- Reset values (asynchronous, immediate):
  - FSM = IDLE.
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o` = 0.
  - `wb_sel_o`, `wb_adr_o`, `wb_dat_o` = 0.
  - FIFO empty; `rvalid_o`, `err_o` = 0; `rdata_o` = 0.
  - `gnt_o` = 1 (empty FIFO, IDLE) once `rst_n` is high.
- A reset mid-transaction drops `cyc/stb` immediately and discards the in-flight transaction and all queued responses.
- Grant at edge N → `wb_cyc_o` high in cycle N+1.
- Ack sampled at edge M → `rvalid_o` high in cycle M+1. Best-case grant-to-rvalid is 2 cycles with a zero-wait slave.
- After termination, a new grant is possible in the very next cycle. Peak throughput is one transaction per 2 cycles.
- Full FIFO (`count == RSP_DEPTH`) holds `gnt_o` low until a pop has been registered.

## Test plan
- **Read, zero-wait slave.** Grant at edge 0 with `addr=0x100`. Slave acks in the first BUS cycle with `0xDEADBEEF`. Required: `wb_cyc_o` high for exactly 1 cycle; `rvalid_o=1`, `rdata_o=0xDEADBEEF`, `err_o=0` one cycle after the ack.
- **Write policy.** Write `be=4'b0011`, `wdata=0x1234_5678`. Required: `wb_sel_o=0011` and `wb_we_o=1`. With `WRITE_RSP=1`, one rvalid beat with `rdata_o=0`; with `WRITE_RSP=0`, no rvalid.
- **Back-pressure.** `RSP_DEPTH=2`, `rready_i=0`, three back-to-back reads. Required: two complete, `gnt_o` stays low for the third. Raising `rready_i` pops them in order, and the third is granted the cycle after the first pop is registered.
- **Error termination.** Assert `wb_err_i` together with `wb_ack_i`. Required: `err_o=1`, `rdata_o=0`.
- **Timeout.** `TIMEOUT_CYCLES=8`, slave never responds. Required: `cyc` high for exactly 8 cycles, then one err=1 response, then `gnt_o=1`.
- **Reset mid-operation.** Pull `rst_n` low during BUS with one response queued. Required: `wb_cyc_o` and `rvalid_o` go to 0 without waiting for a clock edge; after release, a new read completes normally.
